// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared state encoding and word width for the memory responder
package memory_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] ACCESS = 3'd2;
    localparam logic [2:0] DONE   = 3'd3;
    localparam logic [2:0] ERR    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = IDLE,
        ST_WAIT   = WAIT,
        ST_ACCESS = ACCESS,
        ST_DONE   = DONE,
        ST_ERR    = ERR
    } state_t;

endpackage

// File: rtl/ram_sync_32.sv
// rtl/ram_sync_32.sv - single-port synchronous word RAM with registered read data
//
// Ports:
//   clk    rising-edge clock
//   rst    async active-high reset, clears only the read-data register
//   we     write enable: mem[addr] <= wdata at the clock edge
//   re     read enable: rdata <= mem[addr] at the clock edge
//   addr   word address
//   wdata  write data
//   rdata  registered read data, held until the next enabled read
module ram_sync_32
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] wdata,
    output logic [WORD_WIDTH-1:0] rdata
);

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // The array itself is never reset so its contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_responder_32.sv
// rtl/memory_responder_32.sv - MAR/MDR memory responder with wait states and internal RAM
//
// Ports:
//   in_clk      system clock, rising edge
//   in_clr      asynchronous active-high reset
//   in_address  word address from MAR; bits above ADDR_WIDTH-1 must be zero
//   in_data     write data from MDR output
//   in_read     read request, sampled only in IDLE
//   in_write    write request, sampled only in IDLE
//   out_data    read data to MDR; held until the next read completes
//   out_busy    high whenever the FSM is not in IDLE
//   out_done    one-cycle pulse: transaction complete
//   out_error   one-cycle pulse instead of out_done for a rejected request
module memory_responder_32
    import memory_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic                  in_clk,
    input  logic                  in_clr,
    input  logic [WORD_WIDTH-1:0] in_address,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_read,
    input  logic                  in_write,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_busy,
    output logic                  out_done,
    output logic                  out_error
);

    localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                state;
    state_t                next_state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0] data_q;
    logic                  op_write_q;

    logic                  addr_ok;
    logic                  single_req;
    logic                  accept;
    logic                  ram_we;
    logic                  ram_re;

    assign addr_ok    = (in_address >> ADDR_WIDTH) == '0;
    assign single_req = in_read ^ in_write;
    assign accept     = (state == ST_IDLE) && single_req && addr_ok;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (in_read && in_write) begin
                    next_state = ST_ERR;
                end else if (single_req) begin
                    if (!addr_ok) begin
                        next_state = ST_ERR;
                    end else if (WAIT_STATES == 0) begin
                        next_state = ST_ACCESS;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            ST_ERR:    next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // The RAM is only touched in ACCESS, so an abort by reset anywhere earlier
    // leaves memory untouched.
    assign ram_we = (state == ST_ACCESS) && op_write_q;
    assign ram_re = (state == ST_ACCESS) && !op_write_q;

    always_ff @(posedge in_clk or posedge in_clr) begin
        if (in_clr) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            addr_q     <= '0;
            data_q     <= '0;
            op_write_q <= 1'b0;
            out_busy   <= 1'b0;
            out_done   <= 1'b0;
            out_error  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q     <= in_address[ADDR_WIDTH-1:0];
                data_q     <= in_data;
                op_write_q <= in_write;
                wait_cnt   <= CNT_LOAD;
            end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            out_busy  <= (next_state != ST_IDLE);
            // Completion pulses are registered off the terminal states, so they
            // appear in the cycle after DONE/ERR and can never overlap.
            out_done  <= (state == ST_DONE);
            out_error <= (state == ST_ERR);
        end
    end

    ram_sync_32 #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (in_clk),
        .rst   (in_clr),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_memory_responder_32.sv
// tb/tb_memory_responder_32.sv - self-checking bench for memory_responder_32
module tb_memory_responder_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] odata [2];
    logic        busy  [2];
    logic        done  [2];
    logic        err   [2];

    always #5 clk = ~clk;

    memory_responder_32 #(.ADDR_WIDTH(9), .WAIT_STATES(2)) dut_ws2 (
        .in_clk(clk), .in_clr(rst), .in_address(addr[0]), .in_data(wdata[0]),
        .in_read(rd[0]), .in_write(wr[0]), .out_data(odata[0]), .out_busy(busy[0]),
        .out_done(done[0]), .out_error(err[0])
    );

    memory_responder_32 #(.ADDR_WIDTH(9), .WAIT_STATES(0)) dut_ws0 (
        .in_clk(clk), .in_clr(rst), .in_address(addr[1]), .in_data(wdata[1]),
        .in_read(rd[1]), .in_write(wr[1]), .out_data(odata[1]), .out_busy(busy[1]),
        .out_done(done[1]), .out_error(err[1])
    );

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          start;
        int          lat;
    } exp_t;

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        int          is_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    vec_t vecs[12];
    int   edge_cnt = 0;
    int   pass_cnt = 0;
    int   total    = 0;
    int   stray    = 0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? q0.size() : q1.size();
    endfunction

    task automatic mon(input int sel);
        exp_t e;
        if (rst !== 1'b0) return;
        if (done[sel] || err[sel]) begin
            chk("done_err_exclusive", {31'd0, done[sel] & err[sel]}, 32'd0);
            if (qsize(sel) == 0) begin
                stray++;
                $display("FAIL stray_pulse dut%0d done=%b error=%b at %0t", sel, done[sel], err[sel], $time);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                chk("pulse_kind", err[sel] ? 32'd1 : 32'd0, 32'(e.kind));
                chk("out_data", odata[sel], e.data);
                chk("latency", 32'(edge_cnt - e.start), 32'(e.lat));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic clear_in(input int sel);
        rd[sel] = 1'b0; wr[sel] = 1'b0; addr[sel] = 32'd0; wdata[sel] = 32'd0;
    endtask

    task automatic txn(input int sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int is_err, input logic [31:0] exp_data,
                       input int exp_lat, input int exp_busy, input bit junk);
        exp_t e;
        int   bc = 0;
        bit   ok = 1'b0;
        @(negedge clk);
        rd[sel] = r; wr[sel] = w; addr[sel] = a; wdata[sel] = d;
        e.kind = is_err; e.data = exp_data; e.start = edge_cnt + 1; e.lat = exp_lat;
        if (sel == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk);
        #1;
        if (junk) begin
            rd[sel] = 1'b0; wr[sel] = 1'b1; addr[sel] = 32'd6; wdata[sel] = 32'h1234;
        end else begin
            clear_in(sel);
        end
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            #1;
            if (busy[sel]) bc++;
            if (junk && i == 3) clear_in(sel);
            if (qsize(sel) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("completion_timeout", {31'd0, ok}, 32'd1);
        chk("busy_cycles", 32'(bc), 32'(exp_busy));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'd5,         32'hDEADBEEF, 0, 32'h00000000, 4, 4};
        vecs[1]  = '{1'b1, 1'b0, 32'd5,         32'd0,        0, 32'hDEADBEEF, 4, 4};
        vecs[2]  = '{1'b0, 1'b1, 32'd7,         32'h77770007, 0, 32'hDEADBEEF, 4, 4};
        vecs[3]  = '{1'b0, 1'b1, 32'd0,         32'h00000A0A, 0, 32'hDEADBEEF, 4, 4};
        vecs[4]  = '{1'b1, 1'b0, 32'd7,         32'd0,        0, 32'h77770007, 4, 4};
        vecs[5]  = '{1'b1, 1'b1, 32'd0,         32'd1,        1, 32'h77770007, 1, 1};
        vecs[6]  = '{1'b1, 1'b0, 32'h00000200,  32'd0,        1, 32'h77770007, 1, 1};
        vecs[7]  = '{1'b0, 1'b1, 32'h00000200,  32'd5,        1, 32'h77770007, 1, 1};
        vecs[8]  = '{1'b0, 1'b1, 32'd6,         32'h0BADF00D, 0, 32'h77770007, 4, 4};
        vecs[9]  = '{1'b1, 1'b0, 32'd5,         32'd0,        0, 32'hDEADBEEF, 4, 4};
        vecs[10] = '{1'b1, 1'b0, 32'd6,         32'd0,        0, 32'h0BADF00D, 4, 4};
        vecs[11] = '{1'b1, 1'b0, 32'd0,         32'd0,        0, 32'h00000A0A, 4, 4};

        rst = 1'b1;
        clear_in(0);
        clear_in(1);
        #12;
        for (int s = 0; s < 2; s++) begin
            chk("reset_busy",  {31'd0, busy[s]}, 32'd0);
            chk("reset_done",  {31'd0, done[s]}, 32'd0);
            chk("reset_error", {31'd0, err[s]},  32'd0);
            chk("reset_data",  odata[s],         32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            txn(0, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].is_err,
                vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_busy, 1'b0);
        end

        // Write request with new address/data driven while busy must be ignored.
        txn(0, 1'b1, 1'b0, 32'd5, 32'd0, 0, 32'hDEADBEEF, 4, 4, 1'b1);
        txn(0, 1'b1, 1'b0, 32'd6, 32'd0, 0, 32'h0BADF00D, 4, 4, 1'b0);

        // Reset in the middle of a write's wait phase.
        @(negedge clk);
        rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'd7; wdata[0] = 32'hAAAA5555;
        @(posedge clk);
        #1;
        clear_in(0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_busy",  {31'd0, busy[0]}, 32'd0);
        chk("abort_done",  {31'd0, done[0]}, 32'd0);
        chk("abort_error", {31'd0, err[0]},  32'd0);
        chk("abort_data",  odata[0],         32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        txn(0, 1'b1, 1'b0, 32'd7, 32'd0, 0, 32'h77770007, 4, 4, 1'b0);

        // Zero wait-state build.
        txn(1, 1'b0, 1'b1, 32'd511, 32'hFFFFFFFF, 0, 32'h00000000, 2, 2, 1'b0);
        txn(1, 1'b1, 1'b0, 32'd511, 32'd0,        0, 32'hFFFFFFFF, 2, 2, 1'b0);
        txn(1, 1'b1, 1'b1, 32'd511, 32'd3,        1, 32'hFFFFFFFF, 1, 1, 1'b0);
        txn(1, 1'b1, 1'b0, 32'd511, 32'd0,        0, 32'hFFFFFFFF, 2, 2, 1'b0);

        repeat (5) @(negedge clk);
        chk("stray_pulses", 32'(stray), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
